// File: rtl/midi_route_ctrl_pkg.sv
// Shared constants, opcodes and FSM encoding for the MIDI routing controller.
package midi_rt_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_COMMIT = 4'h2;
  localparam logic [3:0] OP_MUTE   = 4'h3;
  localparam logic [3:0] OP_READ   = 4'h4;
  localparam logic [3:0] OP_CLEAR  = 4'h5;

  localparam logic [3:0] STATUS_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EXEC
  } state_e;

  function automatic logic [FRAME_W-1:0] status_word(input logic err);
    return {STATUS_MAGIC, 11'b0, err};
  endfunction

endpackage

// File: rtl/midi_route_ctrl_if.sv
// SPI bus between the MCU (master) and the routing controller (slave).
interface midi_route_ctrl_if;
  logic spi_clk;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_ss, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_ss, input spi_mosi, output spi_miso);
endinterface

// File: rtl/midi_route_ctrl_frontend.sv
// SPI pin synchronizers and edge detectors for the routing controller.
module midi_spi_frontend (
  input  logic clk,
  input  logic nreset,
  input  logic spi_clk_i,
  input  logic spi_ss_i,
  input  logic spi_mosi_i,
  output logic ss_fall_o,
  output logic ss_rise_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic mosi_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sck_prev_q;
  logic       ss_prev_q;

  // Select resets to "asserted" so a frame already in progress at reset release
  // must first be seen going high before a falling edge can start a new one.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sck_sync_q <= 2'b00;
      ss_sync_q  <= 2'b00;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], spi_clk_i};
      ss_sync_q  <= {ss_sync_q[0], spi_ss_i};
      sck_prev_q <= sck_sync_q[1];
      ss_prev_q  <= ss_sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
  end

  assign ss_fall_o  = ss_prev_q & ~ss_sync_q[1];
  assign ss_rise_o  = ~ss_prev_q & ss_sync_q[1];
  assign sck_rise_o = ~sck_prev_q & sck_sync_q[1];
  assign sck_fall_o = sck_prev_q & ~sck_sync_q[1];
  assign mosi_o     = mosi_sync_q[1];

endmodule

// File: rtl/midi_route_ctrl.sv
// SPI command controller driving the MIDI routing tables and mute mask.
// Optional feature: define MIDI_RT_READBACK_EN to enable the READ (0x4) command.
module midi_route_ctrl
  import midi_rt_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  midi_route_ctrl_if.slave         spi,
  output logic [NUM_OUT*SEL_W-1:0] route_sel,
  output logic [NUM_OUT-1:0]       mute,
  output logic                     route_vld,
  output logic                     frame_err
);

  localparam int TW = NUM_OUT * SEL_W;

  function automatic logic [TW-1:0] reset_table();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_OUT; i++) t[i*SEL_W +: SEL_W] = SEL_W'(i);
    return t;
  endfunction

  logic ss_fall, ss_rise, sck_rise, sck_fall, mosi;

  midi_spi_frontend u_frontend (
    .clk        (clk),
    .nreset     (nreset),
    .spi_clk_i  (spi.spi_clk),
    .spi_ss_i   (spi.spi_ss),
    .spi_mosi_i (spi.spi_mosi),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .mosi_o     (mosi)
  );

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   rx_q, rx_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        shadow_q, shadow_d;
  logic [TW-1:0]        route_q, route_d;
  logic [NUM_OUT-1:0]   mute_q, mute_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic [FRAME_W-1:0]   tx_sh_q, tx_sh_d;
  logic                 miso_q, miso_d;
  logic [FRAME_W-1:0]   tx_word;

  logic [3:0] op, addr;
  logic [7:0] data;
  logic       addr_ok;
  logic       unused_data;

  assign op          = rx_q[15:12];
  assign addr        = rx_q[11:8];
  assign data        = rx_q[7:0];
  assign addr_ok     = (int'(addr) < NUM_OUT);
  assign unused_data = ^data;

`ifdef MIDI_RT_READBACK_EN
  logic               rd_pend_q, rd_pend_d;
  logic [FRAME_W-1:0] rd_word_q, rd_word_d;
  logic [SEL_W-1:0]   rd_slot;

  always_comb begin
    rd_slot = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (addr == 4'(i)) rd_slot = shadow_q[i*SEL_W +: SEL_W];
  end

  assign tx_word = rd_pend_q ? rd_word_q : status_word(err_q);
`else
  assign tx_word = status_word(err_q);
`endif

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    route_d   = route_q;
    mute_d    = mute_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    tx_sh_d   = tx_sh_q;
    miso_d    = miso_q;
`ifdef MIDI_RT_READBACK_EN
    rd_pend_d = rd_pend_q;
    rd_word_d = rd_word_q;
`endif
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tx_sh_d   = tx_word;
          miso_d    = tx_word[FRAME_W-1];
`ifdef MIDI_RT_READBACK_EN
          rd_pend_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          miso_d = 1'b0;
          if (bit_cnt_q == 5'd16) begin
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          if (sck_rise) begin
            rx_d      = {rx_q[FRAME_W-2:0], mosi};
            bit_cnt_d = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
          end
          // Zero fill means miso idles low once all 16 bits have gone out.
          if (sck_fall) begin
            miso_d  = tx_sh_q[FRAME_W-2];
            tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (op)
          OP_NOP: ;
          OP_WRITE: begin
            if (addr_ok) begin
              for (int i = 0; i < NUM_OUT; i++)
                if (addr == 4'(i)) shadow_d[i*SEL_W +: SEL_W] = data[SEL_W-1:0];
            end else begin
              err_d = 1'b1;
            end
          end
          OP_COMMIT: begin
            route_d = shadow_q;
            vld_d   = 1'b1;
          end
          OP_MUTE:  mute_d = data[NUM_OUT-1:0];
          OP_CLEAR: err_d  = 1'b0;
`ifdef MIDI_RT_READBACK_EN
          OP_READ: begin
            if (addr_ok) begin
              rd_word_d = {OP_READ, addr, 8'(rd_slot)};
              rd_pend_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
`else
          OP_READ: err_d = 1'b1;
`endif
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shadow_q  <= reset_table();
      route_q   <= reset_table();
      mute_q    <= '1;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      tx_sh_q   <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      route_q   <= route_d;
      mute_q    <= mute_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      tx_sh_q   <= tx_sh_d;
      miso_q    <= miso_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
  end

`ifdef MIDI_RT_READBACK_EN
  always_ff @(posedge clk) begin
    if (!nreset) rd_pend_q <= 1'b0;
    else         rd_pend_q <= rd_pend_d;
  end

  always_ff @(posedge clk) begin
    rd_word_q <= rd_word_d;
  end
`endif

  assign route_sel    = route_q;
  assign mute         = mute_q;
  assign route_vld    = vld_q;
  assign frame_err    = err_q;
  assign spi.spi_miso = miso_q;

endmodule
